// File: rtl/qkt_tile_scheduler.sv
// Control FSM for the Qn x Kn^T tiled matmul: walks output tiles and inner blocks,
// drives operand reads, matmul enable/accumulator clear, and hands tiles downstream.
module qkt_tile_scheduler #(
  parameter int unsigned ROW_TILES    = 2,
  parameter int unsigned COL_TILES    = 3,
  parameter int unsigned INNER_BLOCKS = 4,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned WA_W         = $clog2(ROW_TILES * INNER_BLOCKS),
  parameter int unsigned NA_W         = $clog2(COL_TILES * INNER_BLOCKS),
  parameter int unsigned TR_W         = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1,
  parameter int unsigned TC_W         = (COL_TILES > 1) ? $clog2(COL_TILES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [WA_W-1:0] w_addr,
  output logic [NA_W-1:0] n_addr,
  output logic            rd_en,
  output logic            mm_en,
  output logic            mm_reset_acc,
  input  logic            mm_sys_finish,
  input  logic            mm_acc_done,
  output logic            tile_valid,
  input  logic            tile_ready,
  output logic [TR_W-1:0] tile_row,
  output logic [TC_W-1:0] tile_col
);

  localparam int unsigned KW  = (INNER_BLOCKS > 1) ? $clog2(INNER_BLOCKS) : 1;
  localparam int unsigned LW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_COMPUTE, S_WAIT_ACC, S_OUT, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [TR_W-1:0] row_q, row_d;
  logic [TC_W-1:0] col_q, col_d;
  logic [KW-1:0]   k_q, k_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            acc_seen_q, acc_seen_d;

  logic            busy_q, done_q, error_q, rd_en_q, mm_en_q, clr_q, valid_q;
  logic [WA_W-1:0] w_addr_q;
  logic [NA_W-1:0] n_addr_q;
  logic [TR_W-1:0] trow_q;
  logic [TC_W-1:0] tcol_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    lat_d      = lat_q;
    wd_d       = wd_q;
    acc_seen_d = acc_seen_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      S_CLEAR: begin
        wd_d       = '0;
        acc_seen_d = 1'b0;
        lat_d      = '0;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        if (lat_q == LW'(RD_LAT - 1)) begin
          lat_d   = '0;
          state_d = S_COMPUTE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_COMPUTE: begin
        wd_d = wd_q + WDW'(1);
        if (mm_acc_done) acc_seen_d = 1'b1;
        if (wd_d == WDW'(TIMEOUT)) begin
          state_d = S_ERR;
        end else if (mm_sys_finish) begin
          if (k_q == KW'(INNER_BLOCKS - 1)) begin
            k_d     = '0;
            state_d = S_WAIT_ACC;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_WAIT_ACC: begin
        wd_d = wd_q + WDW'(1);
        if (mm_acc_done) acc_seen_d = 1'b1;
        // acc_done may already have been latched during COMPUTE, or arrive now
        if (wd_d == WDW'(TIMEOUT)) state_d = S_ERR;
        else if (acc_seen_q || mm_acc_done) state_d = S_OUT;
      end
      S_OUT: begin
        if (tile_ready) begin
          if (col_q != TC_W'(COL_TILES - 1)) begin
            col_d   = col_q + TC_W'(1);
            state_d = S_CLEAR;
          end else if (row_q != TR_W'(ROW_TILES - 1)) begin
            col_d   = '0;
            row_d   = row_q + TR_W'(1);
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      lat_q      <= '0;
      wd_q       <= '0;
      acc_seen_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      mm_en_q    <= 1'b0;
      clr_q      <= 1'b0;
      valid_q    <= 1'b0;
      w_addr_q   <= '0;
      n_addr_q   <= '0;
      trow_q     <= '0;
      tcol_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      lat_q      <= lat_d;
      wd_q       <= wd_d;
      acc_seen_q <= acc_seen_d;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_ERR);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERR);
      rd_en_q    <= (state_d == S_FETCH) && (lat_d == '0);
      mm_en_q    <= (state_d == S_COMPUTE);
      clr_q      <= (state_d == S_CLEAR);
      valid_q    <= (state_d == S_OUT);
      if (state_d == S_FETCH || state_d == S_COMPUTE) begin
        w_addr_q <= WA_W'(32'(row_d) * INNER_BLOCKS + 32'(k_d));
        n_addr_q <= NA_W'(32'(col_d) * INNER_BLOCKS + 32'(k_d));
      end else begin
        w_addr_q <= '0;
        n_addr_q <= '0;
      end
      trow_q     <= (state_d == S_OUT) ? row_d : '0;
      tcol_q     <= (state_d == S_OUT) ? col_d : '0;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign rd_en        = rd_en_q;
  assign mm_en        = mm_en_q;
  assign mm_reset_acc = clr_q;
  assign tile_valid   = valid_q;
  assign w_addr       = w_addr_q;
  assign n_addr       = n_addr_q;
  assign tile_row     = trow_q;
  assign tile_col     = tcol_q;

endmodule
